// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: grant state encoding,
// default memory depth and a byte-address to word-index helper.
// Imported by dmem_arbiter and by anything that models the data memory.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_t;

   localparam int RAM_SIZE_DEF = 256;
   localparam int RAM_SIZE_BIT = $clog2(RAM_SIZE_DEF);

   // Word index of a byte address; the two byte-offset bits are dropped.
   function automatic logic [RAM_SIZE_BIT-1:0] word_idx(input logic [31:0] addr);
      return addr[RAM_SIZE_BIT+1:2];
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: grants the lone requester, or i_pref on a tie.
// Latency: combinational, no state.
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports:
//   i_req  [1:0] request vector (bit n = port n)
//   i_pref       port favoured when both request
//   o_gnt  [1:0] one-hot grant, zero when nobody requests
//   o_any        at least one request present
module rr_pick2 (
   input  logic [1:0] i_req,
   input  logic       i_pref,
   output logic [1:0] o_gnt,
   output logic       o_any
);

   always_comb begin
      o_any = |i_req;
      o_gnt = i_req;
      if (&i_req) begin
         o_gnt = i_pref ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU LSU (port 0) and DMA (port 1).
// Latency: access lands the cycle after ownership is decided; lone owner streams 1/cycle.
// Backpressure: a request is held until ack; stall0 freezes the CPU while port 0 waits.
//
// Ports:
//   clk, reset                  clock, async active-low reset
//   reqN/weN/lockN/addrN/wdataN requester N command (held until ackN)
//   ackN/errN/rdataN            requester N response (combinational from state)
//   stall0                      CPU freeze: req0 pending without ack
//   mem_*                       single-cycle data memory bus
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int RAM_SIZE = RAM_SIZE_DEF,
   parameter int MAX_LOCK = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        we0,
   input  logic        lock0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   input  logic        req1,
   input  logic        we1,
   input  logic        lock1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        err0,
   output logic [31:0] rdata0,
   output logic        ack1,
   output logic        err1,
   output logic [31:0] rdata1,
   output logic        stall0,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata
);

   localparam int          LCW        = $clog2(MAX_LOCK) + 1;
   localparam logic [31:0] ADDR_LIMIT = 32'(RAM_SIZE * 4);
   localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

   arb_state_t     r_state;
   logic           r_rr;
   logic [LCW-1:0] r_lock_cnt;

   logic       w_own0, w_own1;
   logic       w_acc0, w_acc1;
   logic       w_inr0, w_inr1;
   logic       w_cur_req, w_cur_lock, w_oth_req;
   logic       w_hold;
   logic       w_pref;
   logic [1:0] w_gnt;
   logic       w_any;
   arb_state_t w_next_owner;

   assign w_own0 = (r_state == ST_OWN0);
   assign w_own1 = (r_state == ST_OWN1);
   assign w_acc0 = w_own0 && req0;
   assign w_acc1 = w_own1 && req1;
   assign w_inr0 = (addr0 < ADDR_LIMIT);
   assign w_inr1 = (addr1 < ADDR_LIMIT);

   // ------------------------------------------------------------------
   // Responses and memory bus, all decoded from the registered owner.
   // ------------------------------------------------------------------
   assign ack0   = w_acc0;
   assign ack1   = w_acc1;
   assign err0   = w_acc0 && !w_inr0;
   assign err1   = w_acc1 && !w_inr1;
   assign rdata0 = (w_acc0 && !we0 && w_inr0) ? mem_rdata : 32'd0;
   assign rdata1 = (w_acc1 && !we1 && w_inr1) ? mem_rdata : 32'd0;
   assign stall0 = req0 && !w_acc0;

   always_comb begin
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      if (w_acc0) begin
         mem_addr  = addr0;
         mem_wdata = wdata0;
         mem_read  = !we0;
         mem_write = we0 && w_inr0;
      end else if (w_acc1) begin
         mem_addr  = addr1;
         mem_wdata = wdata1;
         mem_read  = !we1;
         mem_write = we1 && w_inr1;
      end
   end

   // ------------------------------------------------------------------
   // Next-owner selection. When an owner lets go, the other port is
   // favoured on a tie; from IDLE the stored round-robin pointer decides.
   // ------------------------------------------------------------------
   always_comb begin
      w_cur_req  = 1'b0;
      w_cur_lock = 1'b0;
      w_oth_req  = 1'b0;
      w_pref     = r_rr;
      if (w_own0) begin
         w_cur_req  = req0;
         w_cur_lock = lock0;
         w_oth_req  = req1;
         w_pref     = 1'b1;
      end else if (w_own1) begin
         w_cur_req  = req1;
         w_cur_lock = lock1;
         w_oth_req  = req0;
         w_pref     = 1'b0;
      end
   end

   rr_pick2 u_pick (
      .i_req  ({req1, req0}),
      .i_pref (w_pref),
      .o_gnt  (w_gnt),
      .o_any  (w_any)
   );

   always_comb begin
      w_next_owner = ST_IDLE;
      if (w_any) begin
         w_next_owner = w_gnt[0] ? ST_OWN0 : ST_OWN1;
      end
   end

   // The lock only counts against the owner while the other port waits;
   // an uncontested burst may run indefinitely.
   assign w_hold = w_cur_req && w_cur_lock && (!w_oth_req || (r_lock_cnt < LOCK_LAST));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_rr       <= 1'b0;
         r_lock_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state <= w_next_owner;
            end
            ST_OWN0, ST_OWN1: begin
               if (w_hold) begin
                  if (w_oth_req) begin
                     r_lock_cnt <= r_lock_cnt + LCW'(1);
                  end
               end else begin
                  r_state    <= w_next_owner;
                  r_lock_cnt <= '0;
                  r_rr       <= w_own0;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_lock_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory attached.
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   logic        clk;
   logic        reset;
   logic        req0, we0, lock0, req1, we1, lock1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic        ack0, err0, ack1, err1, stall0;
   logic [31:0] rdata0, rdata1;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write;

   int n_cmp;
   int n_bad;

   logic        mem_init;
   logic [31:0] mem [0:RAM_SIZE_DEF-1];

   dmem_arbiter #(.RAM_SIZE(256), .MAX_LOCK(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .we0       (we0),
      .lock0     (lock0),
      .addr0     (addr0),
      .wdata0    (wdata0),
      .req1      (req1),
      .we1       (we1),
      .lock1     (lock1),
      .addr1     (addr1),
      .wdata1    (wdata1),
      .ack0      (ack0),
      .err0      (err0),
      .rdata0    (rdata0),
      .ack1      (ack1),
      .err1      (err1),
      .rdata1    (rdata1),
      .stall0    (stall0),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: combinational read, write on rising edge. Preload pattern A000_00ii.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < RAM_SIZE_DEF; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      end else if (mem_write) begin
         mem[word_idx(mem_addr)] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[word_idx(mem_addr)];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      mem_init = 1'b1;
      reset = 1'b0;
      req0 = 1'b1; we0 = 1'b0; lock0 = 1'b0; addr0 = 32'h20; wdata0 = 32'h0;
      req1 = 1'b1; we1 = 1'b0; lock1 = 1'b0; addr1 = 32'h24; wdata1 = 32'h0;

      // ---- reset held with both requesting ----
      cyc(); cyc();
      #1;
      check("rst_ack0", {31'd0, ack0}, 32'd0);
      check("rst_ack1", {31'd0, ack1}, 32'd0);
      check("rst_mem_read", {31'd0, mem_read}, 32'd0);
      check("rst_mem_write", {31'd0, mem_write}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_rdata0", rdata0, 32'd0);
      mem_init = 1'b0;

      // ---- release: no ack until the first edge, then port 0 (rr=0) ----
      cyc(); reset = 1'b1; #1;
      check("rel_idle_ack0", {31'd0, ack0}, 32'd0);
      check("rel_idle_stall0", {31'd0, stall0}, 32'd1);

      // ---- round robin reads: 0,1,0,1 ----
      for (int i = 0; i < 4; i++) begin
         cyc(); #1;
         check($sformatf("rr_ack0_%0d", i), {31'd0, ack0}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("rr_ack1_%0d", i), {31'd0, ack1}, (i % 2 == 1) ? 32'd1 : 32'd0);
         check($sformatf("rr_excl_%0d", i), {31'd0, ack0 & ack1}, 32'd0);
         if (i % 2 == 0) check($sformatf("rr_rdata0_%0d", i), rdata0, 32'hA000_0008);
         else            check($sformatf("rr_rdata1_%0d", i), rdata1, 32'hA000_0009);
      end
      // port 0 owns again but drops its request: released with no access
      cyc(); req0 = 1'b0; req1 = 1'b0; #1;
      check("drop_ack0", {31'd0, ack0}, 32'd0);
      check("drop_mem_read", {31'd0, mem_read}, 32'd0);

      // ---- single requester write stream, no bubbles ----
      cyc(); req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h11; #1;
      check("strm_idle_ack0", {31'd0, ack0}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         cyc(); addr0 = 32'(4 * k); wdata0 = 32'h11 * 32'(k + 1); #1;
         check($sformatf("strm_ack0_%0d", k), {31'd0, ack0}, 32'd1);
         check($sformatf("strm_wr_%0d", k), {31'd0, mem_write}, 32'd1);
         check($sformatf("strm_addr_%0d", k), mem_addr, 32'(4 * k));
      end
      cyc(); req0 = 1'b0; we0 = 1'b0; #1;
      check("strm_mem0", mem[0], 32'h11);
      check("strm_mem1", mem[1], 32'h22);
      check("strm_mem2", mem[2], 32'h33);
      check("strm_mem3", mem[3], 32'h44);

      // ---- out of range write then read ----
      cyc(); req0 = 1'b1; we0 = 1'b1; addr0 = 32'h400; wdata0 = 32'hDEAD_BEEF;
      cyc(); #1;
      check("oor_w_ack0", {31'd0, ack0}, 32'd1);
      check("oor_w_err0", {31'd0, err0}, 32'd1);
      check("oor_w_mem_write", {31'd0, mem_write}, 32'd0);
      cyc(); we0 = 1'b0; #1;
      check("oor_r_ack0", {31'd0, ack0}, 32'd1);
      check("oor_r_err0", {31'd0, err0}, 32'd1);
      check("oor_r_rdata0", rdata0, 32'd0);
      check("oor_mem0_kept", mem[0], 32'h11);
      cyc(); req0 = 1'b0; addr0 = 32'h2C;
      cyc();

      // ---- lock limit: port 1 burst of 8, port 0 once, port 1 resumes ----
      cyc(); req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 32'h28;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (i == 0) req0 = 1'b1;
         #1;
         check($sformatf("lock_ack1_%0d", i), {31'd0, ack1}, (i < 8 || i == 9) ? 32'd1 : 32'd0);
         check($sformatf("lock_ack0_%0d", i), {31'd0, ack0}, (i == 8) ? 32'd1 : 32'd0);
         if (i == 8) check("lock_rdata0", rdata0, 32'hA000_000B);
         if (i == 0) check("lock_rdata1", rdata1, 32'hA000_000A);
      end
      cyc(); req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;

      // ---- reset in the middle of a port 1 write ----
      cyc(); req1 = 1'b1; we1 = 1'b1; addr1 = 32'h10; wdata1 = 32'hCAFE_F00D;
      cyc(); #1;
      check("mid_ack1_before", {31'd0, ack1}, 32'd1);
      check("mid_wr_before", {31'd0, mem_write}, 32'd1);
      #1; reset = 1'b0; #1;
      check("mid_ack1_reset", {31'd0, ack1}, 32'd0);
      check("mid_wr_reset", {31'd0, mem_write}, 32'd0);
      cyc(); #1;
      check("mid_mem4_kept", mem[4], 32'hA000_0004);
      reset = 1'b1; #1;
      check("mid_idle_ack1", {31'd0, ack1}, 32'd0);
      cyc(); #1;
      check("mid_reissue_ack1", {31'd0, ack1}, 32'd1);
      cyc(); req1 = 1'b0; we1 = 1'b0; #1;
      check("mid_mem4_written", mem[4], 32'hCAFE_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-cycle CPU's data memory between port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
- Registered grant state machine with round-robin fairness, optional bus lock for bursts, bounded lock length, and an out-of-range address check.
- Sits between the requesters and the data memory, which has a combinational read and a synchronous write on posedge clk.

Parameters:
- RAM_SIZE, 256, memory depth in 32-bit words; byte addresses at or above RAM_SIZE*4 are out of range.
- MAX_LOCK, 8, maximum consecutive locked accesses by one owner while the other port is requesting.

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset
- req0 / req1  input  1  access request, held until ack
- we0 / we1  input  1  1 = write, 0 = read
- lock0 / lock1  input  1  keep ownership after this access (burst)
- addr0 / addr1  input  32  byte address; bits [1:0] ignored
- wdata0 / wdata1  input  32  write data
- ack0 / ack1  output  1  access performed this cycle
- err0 / err1  output  1  with ack: address out of range, no write performed, rdata = 0
- rdata0 / rdata1  output  32  read data, valid when ackN && !weN; 0 otherwise
- stall0  output  1  req0 && !ack0; CPU freezes its PC on this
- mem_addr  output  32  to memory Address
- mem_wdata  output  32  to memory Write_data
- mem_read  output  1  to memory MemRead
- mem_write  output  1  to memory MemWrite
- mem_rdata  input  32  from memory Read_data

Behaviour:
- States: IDLE, OWN0, OWN1, held in a registered state. Also registered: rr (1 bit, port favoured next on a tie) and lock_cnt (clog2(MAX_LOCK)+1 bits).
- Reset (asynchronous, reset=0):
  - state=IDLE, rr=0, lock_cnt=0.
  - All outputs are combinational from state, so every ack/err/mem_read/mem_write = 0 and mem_addr/mem_wdata/rdata = 0.
- Access cycle: state==OWNn && reqn=1.
  - ackn=1.
  - Memory bus is muxed from port n: mem_read = !wen, mem_write = wen && in_range.
  - rdatan = mem_rdata when in_range, else 0. A write commits at the posedge ending the cycle.
  - errn = !in_range, where in_range = addrn < RAM_SIZE*4.
- Non-owner port: ack=0, rdata=0. In IDLE the memory bus is all zero.
- Arbitrate(pref), combinational next owner:
  - Both requesting: owner = pref.
  - One requesting: that port.
  - None requesting: IDLE.
- Transitions:
  - IDLE: next = arbitrate(rr). First access lands one cycle after req rises, so minimum latency is 1 cycle.
  - OWNn with reqn=1 and lockn=1 and (other not requesting or lock_cnt < MAX_LOCK-1): stay OWNn, lock_cnt += 1 if the other port is requesting, else hold.
  - OWNn, all other cases (access done without lock, lock limit reached, or reqn=0): next = arbitrate(other port), lock_cnt=0, rr = other port.
  - A lone requester therefore stays owner back-to-back at 1 access/cycle with no bubble.
- Lock limit: with the other port requesting, the owner gets at most MAX_LOCK consecutive accesses, then must yield for at least one access.
- Ownership change costs no dead cycle; the new owner's access occurs in the cycle after the decision.
- Request rules:
  - A requester keeps req/we/addr/wdata stable until ack.
  - Dropping req before ack is legal; the arbiter releases ownership without accessing memory.
- Reset mid-access: state returns to IDLE immediately, the in-flight write is not committed, and the requester must re-issue.
- Both ports never receive ack in the same cycle (mutual exclusion invariant).

Decomposition:
- Shared package dmem_pkg: state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2), RAM_SIZE default, a word-index helper (addr[RAM_SIZE_BIT+1:2]).
- One natural sub-module: rr_pick2. It is combinational: inputs two requests and pref, outputs grant vector plus any-request flag. Reused by the future I/O-bus arbiter.

Test Plan:
- Reset: hold reset=0 with req0=req1=1 -> all ack/mem_* = 0. Release -> first ack0 (rr=0) in the cycle after the first posedge.
- Single requester stream: req0=1 for 4 cycles, we0=1, addr 0x00,0x04,0x08,0x0C, data 0x11..0x44 -> ack0 in 4 consecutive cycles. Memory words 0..3 = 0x11,0x22,0x33,0x44.
- Round-robin: req0 and req1 held, no lock, reads -> ack alternates 0,1,0,1. Each port's rdata matches preloaded memory; ack0 && ack1 never both 1.
- Lock limit: MAX_LOCK=8, lock1=req1=1 continuously, req0=1 -> ack1 for 8 consecutive cycles, then ack0 for one cycle, then port 1 resumes.
- Out-of-range: we0=1, addr0=0x400 (RAM_SIZE=256), wdata 0xDEADBEEF -> ack0=1, err0=1, mem_write=0, memory unchanged. Read of 0x400 -> rdata0=0.
- Reset mid-access: OWN1 write cycle to 0x10 with reset falling before the posedge -> word 4 unchanged, state IDLE, ack1=0.
